// File: rtl/spad_access_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// spad_access_arbiter_pkg
//   Shared definitions for the scratchpad access arbiter: default widths and
//   the controller state encoding.
// ---------------------------------------------------------------------------
package spad_access_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } spad_state_e;

endpackage : spad_access_arbiter_pkg

// File: rtl/spad_access_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin selector. Produces a one-hot selection from the
//   request pair based on the priority pointer; the pointer moves past the
//   selected requester only when the parent asserts advance (i.e. the
//   selection was actually granted).
//
// Ports
//   clk      in   clock
//   rstn     in   asynchronous active-low reset (pointer returns to req[0])
//   req      in   [1:0] request vector
//   advance  in   selection was granted this cycle; rotate the pointer
//   sel      out  [1:0] one-hot selection (zero when no request)
// ---------------------------------------------------------------------------
module rr_arb2
    import spad_access_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] sel
);

    // 0: req[0] has priority, 1: req[1] has priority
    logic ptr;

    always_comb begin
        sel = 2'b00;
        if (!ptr) begin
            if (req[0])      sel = 2'b01;
            else if (req[1]) sel = 2'b10;
        end else begin
            if (req[1])      sel = 2'b10;
            else if (req[0]) sel = 2'b01;
        end
    end

    // After granting requester 0 point at 1, and vice versa.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= sel[0];
        end
    end

endmodule : rr_arb2

// File: rtl/spad_access_arbiter.sv
// ---------------------------------------------------------------------------
// spad_access_arbiter
//   Arbitrates two read requesters and one write requester onto an external
//   single-cycle-latency SRAM scratchpad, and provides a bulk clear that
//   writes zero to every entry.
//
// Ports
//   clk, rstn               clock, asynchronous active-low reset
//   rd0_valid/ready/addr    read requester 0 handshake and address
//   rd0_rvalid              read response pulse for requester 0
//   rd1_valid/ready/addr    read requester 1 handshake and address
//   rd1_rvalid              read response pulse for requester 1
//   rd_rdata                shared read data (passes sp_dout through)
//   wr_valid/ready          write handshake
//   wr_addr, wr_data        write address and data
//   clr_req                 request a full clear
//   clr_busy, clr_done      clear in progress; one-cycle completion pulse
//   sp_chip_en/ren/wen      SRAM controls
//   sp_raddr/waddr/din      SRAM addresses and write data
//   sp_dout                 SRAM registered read data
// ---------------------------------------------------------------------------
module spad_access_arbiter
    import spad_access_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  rd0_valid,
    output logic                  rd0_ready,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic                  rd0_rvalid,

    input  logic                  rd1_valid,
    output logic                  rd1_ready,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rd1_rvalid,

    output logic [DATA_WIDTH-1:0] rd_rdata,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,

    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done,

    output logic                  sp_chip_en,
    output logic                  sp_ren,
    output logic                  sp_wen,
    output logic [ADDR_WIDTH-1:0] sp_raddr,
    output logic [ADDR_WIDTH-1:0] sp_waddr,
    output logic [DATA_WIDTH-1:0] sp_din,
    input  logic [DATA_WIDTH-1:0] sp_dout
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    spad_state_e           state, next_state;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    logic                  run_idle;
    logic                  in_clear;
    logic                  wr_acc;
    logic                  hazard;
    logic [1:0]            rr_req;
    logic [1:0]            rr_sel;
    logic [1:0]            grant;
    logic                  rr_adv;
    logic [ADDR_WIDTH-1:0] sel_addr;

    // rstn gates the combinational handshakes so readies and SRAM strobes
    // drop immediately on reset assertion, not at the next clock.
    assign run_idle = rstn && (state == IDLE);
    assign in_clear = rstn && (state == CLEAR);
    assign rr_req   = run_idle ? {rd1_valid, rd0_valid} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rstn    (rstn),
        .req     (rr_req),
        .advance (rr_adv),
        .sel     (rr_sel)
    );

    always_comb begin
        wr_ready   = run_idle;
        wr_acc     = wr_valid && run_idle;
        sel_addr   = rr_sel[1] ? rd1_addr : rd0_addr;
        // The selected reader yields to a same-address write; the other
        // reader is not promoted in its place, so both readies stay low.
        hazard     = wr_acc && (rr_sel != 2'b00) && (sel_addr == wr_addr);
        grant      = hazard ? 2'b00 : rr_sel;
        rr_adv     = (grant != 2'b00);

        rd0_ready  = grant[0];
        rd1_ready  = grant[1];

        sp_ren     = 1'b0;
        sp_wen     = 1'b0;
        sp_raddr   = '0;
        sp_waddr   = '0;
        sp_din     = '0;

        if (grant != 2'b00) begin
            sp_ren   = 1'b1;
            sp_raddr = sel_addr;
        end

        if (wr_acc) begin
            sp_wen   = 1'b1;
            sp_waddr = wr_addr;
            sp_din   = wr_data;
        end else if (in_clear) begin
            sp_wen   = 1'b1;
            sp_waddr = clr_cnt;
            sp_din   = '0;
        end

        sp_chip_en = sp_ren || sp_wen;
        clr_busy   = (state == CLEAR);
        rd_rdata   = sp_dout;

        next_state = state;
        case (state)
            IDLE:    if (clr_req)              next_state = CLEAR;
            CLEAR:   if (clr_cnt == LAST_ADDR) next_state = IDLE;
            default:                           next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clr_done   <= 1'b0;
            rd0_rvalid <= 1'b0;
            rd1_rvalid <= 1'b0;
        end else begin
            state      <= next_state;
            clr_done   <= (state == CLEAR) && (clr_cnt == LAST_ADDR);
            rd0_rvalid <= grant[0];
            rd1_rvalid <= grant[1];
            if ((state == CLEAR) && (clr_cnt != LAST_ADDR)) begin
                clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
            end else begin
                clr_cnt <= '0;
            end
        end
    end

endmodule : spad_access_arbiter

// File: tb/tb_spad_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spad_access_arbiter
//   Directed bench for spad_access_arbiter with a behavioural SRAM that has a
//   one-cycle registered read. Inputs change 1 ns after the rising edge;
//   combinational outputs are sampled 2 ns after it.
// ---------------------------------------------------------------------------
module tb_spad_access_arbiter;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rd0_valid, rd0_ready, rd0_rvalid;
    logic          rd1_valid, rd1_ready, rd1_rvalid;
    logic [AW-1:0] rd0_addr, rd1_addr;
    logic [DW-1:0] rd_rdata;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr_req, clr_busy, clr_done;
    logic          sp_chip_en, sp_ren, sp_wen;
    logic [AW-1:0] sp_raddr, sp_waddr;
    logic [DW-1:0] sp_din, sp_dout;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    spad_access_arbiter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rd0_valid  (rd0_valid),
        .rd0_ready  (rd0_ready),
        .rd0_addr   (rd0_addr),
        .rd0_rvalid (rd0_rvalid),
        .rd1_valid  (rd1_valid),
        .rd1_ready  (rd1_ready),
        .rd1_addr   (rd1_addr),
        .rd1_rvalid (rd1_rvalid),
        .rd_rdata   (rd_rdata),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .sp_chip_en (sp_chip_en),
        .sp_ren     (sp_ren),
        .sp_wen     (sp_wen),
        .sp_raddr   (sp_raddr),
        .sp_waddr   (sp_waddr),
        .sp_din     (sp_din),
        .sp_dout    (sp_dout)
    );

    // SRAM model; preload puts 0x1000+i in entry i.
    logic          preload;
    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(32'h1000 + i);
        end else if (sp_wen) begin
            mem[sp_waddr] <= sp_din;
        end
        if (sp_ren) sp_dout <= mem[sp_raddr];
    end

    // {rd1_ready, rd0_ready, wr_ready, sp_ren, sp_wen, sp_chip_en,
    //  clr_busy, clr_done, rd1_rvalid, rd0_rvalid}
    logic [9:0] st;
    assign st = {rd1_ready, rd0_ready, wr_ready, sp_ren, sp_wen, sp_chip_en,
                 clr_busy, clr_done, rd1_rvalid, rd0_rvalid};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; preload = 1'b1;
        rd0_valid = 1'b1; rd0_addr = 4'd1;
        rd1_valid = 1'b1; rd1_addr = 4'd2;
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
        clr_req = 1'b1;
        #2;
        nvec++;
        if (st !== 10'h000 || sp_raddr !== 4'd0 || sp_waddr !== 4'd0 || sp_din !== 16'h0) begin
            nerr++;
            $display("FAIL reset_async st=%b raddr=%0d waddr=%0d din=%h exp st=0 all zero",
                     st, sp_raddr, sp_waddr, sp_din);
        end
        tick; tick;
        nvec++;
        if (st !== 10'h000) begin
            nerr++;
            $display("FAIL reset_held st=%b exp=%b", st, 10'h000);
        end
        rd0_valid = 1'b0; rd1_valid = 1'b0; wr_valid = 1'b0; clr_req = 1'b0;
        preload = 1'b0;
        rstn = 1'b1;
        tick;
        #1;
        nvec++;
        if (st !== 10'h080) begin
            nerr++;
            $display("FAIL reset_idle st=%b exp=%b", st, 10'h080);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0]    exp_rdy;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        tick;
        rd0_addr = 4'd3; rd1_addr = 4'd5;
        rd0_valid = 1'b1; rd1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_rdy  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (i % 2 == 0) ? 4'd3 : 4'd5;
            exp_data = (i % 2 == 0) ? 16'h1003 : 16'h1005;
            #1;
            nvec++;
            if ({rd1_ready, rd0_ready} !== exp_rdy || sp_raddr !== exp_addr || sp_ren !== 1'b1) begin
                nerr++;
                $display("FAIL rr_grant[%0d] rdy=%b raddr=%0d ren=%b exp rdy=%b raddr=%0d ren=1",
                         i, {rd1_ready, rd0_ready}, sp_raddr, sp_ren, exp_rdy, exp_addr);
            end
            tick;
            if (i == 3) begin
                rd0_valid = 1'b0; rd1_valid = 1'b0;
            end
            nvec++;
            if ({rd1_rvalid, rd0_rvalid} !== exp_rdy || rd_rdata !== exp_data) begin
                nerr++;
                $display("FAIL rr_resp[%0d] rvalid=%b rdata=%h exp rvalid=%b rdata=%h",
                         i, {rd1_rvalid, rd0_rvalid}, rd_rdata, exp_rdy, exp_data);
            end
        end
    endtask

    task automatic test_write_then_read;
        tick;
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 16'h00A5;
        #1;
        nvec++;
        if (st !== 10'h0B0 || sp_waddr !== 4'd2 || sp_din !== 16'h00A5 || sp_raddr !== 4'd0) begin
            nerr++;
            $display("FAIL wtr_write st=%b waddr=%0d din=%h raddr=%0d exp st=%b waddr=2 din=00a5 raddr=0",
                     st, sp_waddr, sp_din, sp_raddr, 10'h0B0);
        end
        tick;
        wr_valid = 1'b0; rd0_valid = 1'b1; rd0_addr = 4'd2;
        #1;
        nvec++;
        if ({rd1_ready, rd0_ready} !== 2'b01 || sp_raddr !== 4'd2 || sp_wen !== 1'b0
            || sp_waddr !== 4'd0 || sp_din !== 16'h0) begin
            nerr++;
            $display("FAIL wtr_grant rdy=%b raddr=%0d wen=%b waddr=%0d din=%h exp rdy=01 raddr=2 wen=0 waddr=0 din=0",
                     {rd1_ready, rd0_ready}, sp_raddr, sp_wen, sp_waddr, sp_din);
        end
        tick;
        rd0_valid = 1'b0;
        #1;
        nvec++;
        if ({rd1_rvalid, rd0_rvalid} !== 2'b01 || rd_rdata !== 16'h00A5) begin
            nerr++;
            $display("FAIL wtr_resp rvalid=%b rdata=%h exp rvalid=01 rdata=00a5",
                     {rd1_rvalid, rd0_rvalid}, rd_rdata);
        end
    endtask

    // Pointer is at rd1 on entry.
    task automatic test_hazard;
        tick;
        wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 16'h5A5A;
        rd1_valid = 1'b1; rd1_addr = 4'd7;
        rd0_valid = 1'b1; rd0_addr = 4'd4;
        #1;
        nvec++;
        if ({rd1_ready, rd0_ready} !== 2'b00 || sp_ren !== 1'b0 || sp_wen !== 1'b1
            || sp_waddr !== 4'd7 || sp_din !== 16'h5A5A || sp_raddr !== 4'd0) begin
            nerr++;
            $display("FAIL hz_block rdy=%b ren=%b wen=%b waddr=%0d din=%h raddr=%0d exp rdy=00 ren=0 wen=1 waddr=7 din=5a5a raddr=0",
                     {rd1_ready, rd0_ready}, sp_ren, sp_wen, sp_waddr, sp_din, sp_raddr);
        end
        tick;
        wr_valid = 1'b0;
        #1;
        nvec++;
        if ({rd1_ready, rd0_ready} !== 2'b10 || sp_raddr !== 4'd7 || {rd1_rvalid, rd0_rvalid} !== 2'b00) begin
            nerr++;
            $display("FAIL hz_retry rdy=%b raddr=%0d rvalid=%b exp rdy=10 raddr=7 rvalid=00",
                     {rd1_ready, rd0_ready}, sp_raddr, {rd1_rvalid, rd0_rvalid});
        end
        tick;
        rd1_valid = 1'b0;
        #1;
        nvec++;
        if ({rd1_rvalid, rd0_rvalid} !== 2'b10 || rd_rdata !== 16'h5A5A
            || {rd1_ready, rd0_ready} !== 2'b01 || sp_raddr !== 4'd4) begin
            nerr++;
            $display("FAIL hz_resp rvalid=%b rdata=%h rdy=%b raddr=%0d exp rvalid=10 rdata=5a5a rdy=01 raddr=4",
                     {rd1_rvalid, rd0_rvalid}, rd_rdata, {rd1_ready, rd0_ready}, sp_raddr);
        end
        tick;
        rd0_valid = 1'b0;
        #1;
        nvec++;
        if ({rd1_rvalid, rd0_rvalid} !== 2'b01 || rd_rdata !== 16'h1004) begin
            nerr++;
            $display("FAIL hz_resp2 rvalid=%b rdata=%h exp rvalid=01 rdata=1004",
                     {rd1_rvalid, rd0_rvalid}, rd_rdata);
        end
    endtask

    // Pointer is at rd1 on entry.
    task automatic test_clear;
        logic [9:0] exp_st;
        tick;
        clr_req = 1'b1; rd1_valid = 1'b1; rd1_addr = 4'd5;
        #1;
        nvec++;
        if ({rd1_ready, rd0_ready} !== 2'b10 || sp_raddr !== 4'd5 || clr_busy !== 1'b0) begin
            nerr++;
            $display("FAIL clr_req_grant rdy=%b raddr=%0d busy=%b exp rdy=10 raddr=5 busy=0",
                     {rd1_ready, rd0_ready}, sp_raddr, clr_busy);
        end
        tick;
        clr_req = 1'b0;
        rd0_valid = 1'b1; rd0_addr = 4'd3;
        wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 16'hFFFF;
        for (int k = 0; k < DEPTH; k++) begin
            exp_st = (k == 0) ? 10'h03A : 10'h038;
            #1;
            nvec++;
            if (st !== exp_st || sp_waddr !== AW'(k) || sp_din !== 16'h0 || sp_raddr !== 4'd0
                || (k == 0 && rd_rdata !== 16'h1005)) begin
                nerr++;
                $display("FAIL clr_cycle[%0d] st=%b waddr=%0d din=%h raddr=%0d rdata=%h exp st=%b waddr=%0d din=0 raddr=0",
                         k, st, sp_waddr, sp_din, sp_raddr, rd_rdata, exp_st, k);
            end
            if (k == DEPTH - 1) wr_valid = 1'b0;
            tick;
        end
        #1;
        nvec++;
        if (st !== 10'h1D4 || sp_raddr !== 4'd3) begin
            nerr++;
            $display("FAIL clr_done st=%b raddr=%0d exp st=%b raddr=3", st, sp_raddr, 10'h1D4);
        end
        tick;
        #1;
        nvec++;
        if (st !== 10'h2D1 || rd_rdata !== 16'h0 || sp_raddr !== 4'd5) begin
            nerr++;
            $display("FAIL clr_after0 st=%b rdata=%h raddr=%0d exp st=%b rdata=0 raddr=5",
                     st, rd_rdata, sp_raddr, 10'h2D1);
        end
        tick;
        rd1_valid = 1'b0; rd0_addr = 4'd7;
        #1;
        nvec++;
        if ({rd1_rvalid, rd0_rvalid} !== 2'b10 || rd_rdata !== 16'h0
            || {rd1_ready, rd0_ready} !== 2'b01 || sp_raddr !== 4'd7 || clr_done !== 1'b0) begin
            nerr++;
            $display("FAIL clr_after1 rvalid=%b rdata=%h rdy=%b raddr=%0d done=%b exp rvalid=10 rdata=0 rdy=01 raddr=7 done=0",
                     {rd1_rvalid, rd0_rvalid}, rd_rdata, {rd1_ready, rd0_ready}, sp_raddr, clr_done);
        end
        tick;
        rd0_valid = 1'b0;
        #1;
        nvec++;
        if ({rd1_rvalid, rd0_rvalid} !== 2'b01 || rd_rdata !== 16'h0) begin
            nerr++;
            $display("FAIL clr_after2 rvalid=%b rdata=%h exp rvalid=01 rdata=0",
                     {rd1_rvalid, rd0_rvalid}, rd_rdata);
        end
    endtask

    task automatic test_reset_abort;
        tick;
        clr_req = 1'b1;
        tick;
        clr_req = 1'b0; rd0_valid = 1'b1; rd0_addr = 4'd3;
        repeat (6) tick;
        #1;
        nvec++;
        if (sp_waddr !== 4'd6 || clr_busy !== 1'b1) begin
            nerr++;
            $display("FAIL abort_pre waddr=%0d busy=%b exp waddr=6 busy=1", sp_waddr, clr_busy);
        end
        rstn = 1'b0;
        #1;
        nvec++;
        if (st !== 10'h000 || sp_waddr !== 4'd0 || sp_din !== 16'h0 || sp_raddr !== 4'd0) begin
            nerr++;
            $display("FAIL abort_clr_async st=%b waddr=%0d din=%h raddr=%0d exp all zero",
                     st, sp_waddr, sp_din, sp_raddr);
        end
        tick; tick;
        rd0_valid = 1'b0;
        rstn = 1'b1;
        tick;
        nvec++;
        if (st !== 10'h080) begin
            nerr++;
            $display("FAIL abort_clr_idle st=%b exp=%b", st, 10'h080);
        end
        tick;
        nvec++;
        if (st !== 10'h080) begin
            nerr++;
            $display("FAIL abort_clr_nodone st=%b exp=%b", st, 10'h080);
        end
        // Reset between a read grant and its response.
        rd0_valid = 1'b1; rd0_addr = 4'd3;
        #1;
        nvec++;
        if ({rd1_ready, rd0_ready} !== 2'b01) begin
            nerr++;
            $display("FAIL abort_rd_grant rdy=%b exp=01", {rd1_ready, rd0_ready});
        end
        rstn = 1'b0;
        #1;
        nvec++;
        if ({rd1_ready, rd0_ready} !== 2'b00 || sp_ren !== 1'b0) begin
            nerr++;
            $display("FAIL abort_rd_async rdy=%b ren=%b exp rdy=00 ren=0", {rd1_ready, rd0_ready}, sp_ren);
        end
        tick;
        rd0_valid = 1'b0;
        #1;
        rstn = 1'b1;
        #1;
        nvec++;
        if (st !== 10'h080) begin
            nerr++;
            $display("FAIL abort_rd_norvalid st=%b exp=%b", st, 10'h080);
        end
        tick;
        nvec++;
        if (st !== 10'h080) begin
            nerr++;
            $display("FAIL abort_rd_after st=%b exp=%b", st, 10'h080);
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_write_then_read;
        test_hazard;
        test_clear;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_spad_access_arbiter

// File: doc/spad_access_arbiter.md
SPAD_ACCESS_ARBITER -- requirements
Module: spad_access_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the scratchpad word width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the scratchpad entry count.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, meaning the scratchpad address width, with 2^ADDR_WIDTH >= DEPTH.
REQ-004 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rstn  in  1  reset, asynchronous and active-low.
REQ-006 rdN_valid/rdN_ready (N=0,1)  in/out  1/1  read request handshake per requester.
REQ-007 rdN_addr  in  ADDR_WIDTH  read address per requester.
REQ-008 rdN_rvalid  out  1  one-cycle pulse: read data is valid for requester N.
REQ-009 rd_rdata  out  DATA_WIDTH  shared read data, which SHALL equal sp_dout.
REQ-010 wr_valid/wr_ready  in/out  1/1  write request handshake.
REQ-011 wr_addr, wr_data  in  ADDR_WIDTH, DATA_WIDTH  write address and write data.
REQ-012 clr_req  in  1  request to zero the whole scratchpad.
REQ-013 clr_busy, clr_done  out  1/1  clear is in progress; one-cycle pulse when the clear completes.
REQ-014 sp_chip_en, sp_ren, sp_wen  out  1 each  SRAM scratchpad controls.
REQ-015 sp_raddr, sp_waddr, sp_din  out  ADDR_WIDTH, ADDR_WIDTH, DATA_WIDTH  SRAM scratchpad address and data.
REQ-016 sp_dout  in  DATA_WIDTH  SRAM scratchpad registered read data (1-cycle latency).

Function
REQ-017 FSM states SHALL be IDLE and CLEAR.
REQ-018 IDLE to CLEAR SHALL occur on the cycle after clr_req=1 is sampled in IDLE.
- Grants in the cycle clr_req is sampled still proceed.
REQ-019 In CLEAR, behaviour SHALL be:
- sp_wen=1, sp_waddr=clr_cnt, sp_din=0, clr_cnt counting 0..DEPTH-1, one write per cycle;
- all readies held at 0;
- clr_req ignored.
REQ-020 After the write to DEPTH-1, the block SHALL return to IDLE and pulse clr_done for exactly one cycle; clr_busy=1 exactly while in CLEAR.
REQ-021 In IDLE, wr_ready SHALL be 1, so a write is accepted when wr_valid=1.
- An accepted write drives sp_wen=1, sp_waddr=wr_addr, sp_din=wr_data in the same cycle.
REQ-022 Read arbitration in IDLE SHALL be round-robin over valid requesters.
- The rr pointer starts at rd0.
- After a grant to N, the pointer moves to the other requester; it is unchanged with no grant.
- A single valid requester is granted whenever no hazard exists.
REQ-023 A read grant SHALL assert rdN_ready=1, sp_ren=1 and sp_raddr=rdN_addr in the same cycle; at most one rdN_ready is 1 per cycle.
REQ-024 Hazard rule: if the selected reader's address equals the address of a write accepted in the same cycle:
- no read is issued and both readies are 0;
- the pointer does not advance;
- the write proceeds;
- the read retries the next cycle.
REQ-025 A read granted in cycle t SHALL give rdN_rvalid=1 in cycle t+1, tagged to the granted N, with rd_rdata=sp_dout; there is no response backpressure.
REQ-026 A read granted in the cycle clr_req is sampled SHALL still deliver its response in the first CLEAR cycle.
REQ-027 sp_chip_en SHALL equal sp_ren OR sp_wen.
REQ-028 Inactive sp_* address and data outputs SHALL be 0.

Reset
REQ-029 While rstn=0, the following SHALL hold asynchronously:
- state=IDLE, clr_cnt=0, pointer=rd0;
- rdN_rvalid=0, clr_busy=0, clr_done=0;
- all sp_* outputs 0, all readies 0.
REQ-030 Reset asserted mid-CLEAR or mid-read SHALL abort the operation with no response or clr_done pulse; after release, the block starts in IDLE with no stale rvalid.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=0, CLEAR=1) and the default-width constants.
REQ-032 Round-robin selection SHALL be a sub-module rr_arb2 (two requests, pointer register, grant out, advance enable); the SRAM itself is external.

Verification
REQ-033 rd0 and rd1 both valid (addr 3, 5) for 4 cycles -> grants rd0, rd1, rd0, rd1; rvalid tags follow one cycle later.
REQ-034 Write addr 2 data 0xA5, then read addr 2 the next cycle -> rd0_rvalid one cycle after the grant with rd_rdata=0xA5.
REQ-035 Write addr 7 plus rd1 read addr 7 in the same cycle -> rd1_ready=0 and the write occurs; rd1 is granted the next cycle and returns the new data.
REQ-036 clr_req with DEPTH=16 -> clr_busy high 16 cycles, sp_waddr 0..15 with sp_din=0, then one clr_done pulse; rdN_valid held high is not granted during CLEAR, and all reads afterwards return 0.
REQ-037 rstn dropped at clr_cnt=6 -> all outputs 0 immediately; after release, state IDLE with no clr_done pulse.
REQ-038 Read granted in the same cycle as clr_req -> its rvalid appears in the first CLEAR cycle with the correct tag.
